// File: rtl/seq_alu_core.sv
// Handshaked W-bit ALU: add, sign/magnitude subtract, average (single cycle)
// and an iterative shift-add multiply that takes W cycles.
module seq_alu_core #(
    parameter int W = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           IN_VALID,
    output logic           IN_READY,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic [1:0]     OP,
    output logic           OUT_VALID,
    input  logic           OUT_READY,
    output logic [2*W-1:0] Y,
    output logic           ZERO
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] y_q, y_d;
    logic           zero_q, zero_d;
    logic           vld_q, vld_d;

    logic           accept;
    logic [W:0]     step_sum;
    logic [2*W-1:0] acc_step;
    logic [2*W-1:0] alu_res;

    function automatic logic [2*W-1:0] alu_result(
        input logic [1:0]   op,
        input logic [W-1:0] a,
        input logic [W-1:0] b
    );
        logic [W:0]   sum;
        logic         sign;
        logic [W-1:0] mag;
        sum  = {1'b0, a} + {1'b0, b};
        sign = (a < b);
        mag  = sign ? (b - a) : (a - b);
        case (op)
            2'b00:   alu_result = {{(W-1){1'b0}}, sum};
            2'b01:   alu_result = {{(W-1){1'b0}}, sign, mag};
            default: alu_result = {{W{1'b0}}, sum[W:1]};
        endcase
    endfunction

    assign IN_READY  = (state_q == S_IDLE) || ((state_q == S_DONE) && OUT_READY);
    assign accept    = IN_VALID && IN_READY;
    assign alu_res   = alu_result(OP, A, B);

    // Upper half accumulates the multiplicand; the W+1-bit sum keeps the carry
    // that the right shift then moves into the top bit.
    assign step_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (mplier_q[0] ? mcand_q : {W{1'b0}})};
    assign acc_step  = {step_sum, acc_q[W-1:1]};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        zero_d   = zero_q;
        vld_d    = vld_q;

        case (state_q)
            S_MUL: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    y_d     = acc_step;
                    zero_d  = (acc_step == '0);
                    vld_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (OUT_READY) begin
                    vld_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // An accept in DONE overrides the drain so a new op starts on the same edge.
        if (accept) begin
            if (OP == 2'b10) begin
                acc_d    = '0;
                mcand_d  = A;
                mplier_d = B;
                cnt_d    = '0;
                vld_d    = 1'b0;
                state_d  = S_MUL;
            end else begin
                y_d      = alu_res;
                zero_d   = (alu_res == '0);
                vld_d    = 1'b1;
                state_d  = S_DONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            y_q      <= '0;
            zero_q   <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
            vld_q    <= vld_d;
        end
    end

    assign Y         = y_q;
    assign ZERO      = zero_q;
    assign OUT_VALID = vld_q;

endmodule
